// File: rtl/morse_round_controller.sv
// Game sequencer for the Morse number trainer: it picks a target digit, plays it on the lamp,
// waits for the player's answer or a timeout, and keeps the score and round count for the game.
module morse_round_controller #(
    parameter int DOT_UNITS     = 1,
    parameter int DASH_UNITS    = 3,
    parameter int GAP_UNITS     = 1,
    parameter int TIMEOUT_UNITS = 64,
    parameter int ROUNDS        = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       start,
    input  logic [3:0] morse_number,
    input  logic       answer_valid,
    input  logic [3:0] answer_digit,
    output logic [3:0] q,
    output logic       led,
    output logic       busy,
    output logic       await_answer,
    output logic       correct,
    output logic       wrong,
    output logic [3:0] score,
    output logic [3:0] round,
    output logic       game_over
);

    localparam int MAX_UNITS = (DASH_UNITS > TIMEOUT_UNITS) ? DASH_UNITS : TIMEOUT_UNITS;
    localparam int CW        = $clog2(MAX_UNITS + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_PLAY_ON  = 3'd2,
        S_PLAY_GAP = 3'd3,
        S_WAIT_ANS = 3'd4,
        S_RESULT   = 3'd5,
        S_OVER     = 3'd6
    } state_t;

    state_t        state_r, state_nx;
    logic [3:0]    q_r;
    logic [3:0]    target_r, target_nx;
    logic [2:0]    sym_r, sym_nx;
    logic [CW-1:0] cnt_r, cnt_nx;
    logic [3:0]    score_r, score_nx;
    logic [3:0]    round_r, round_nx;
    logic          hit_r, hit_nx;
    logic [CW-1:0] cnt_inc_s;
    logic [CW-1:0] on_len_s;

    // Digits 1-5 lead with dots, 6-9 lead with dashes; 0 and out-of-range codes are all dashes.
    function automatic logic is_dash(input logic [3:0] d, input logic [2:0] s);
        logic r;
        r = 1'b1;
        if ((d >= 4'd1) && (d <= 4'd5)) begin
            r = ({1'b0, s} >= d);
        end else if ((d >= 4'd6) && (d <= 4'd9)) begin
            r = ({1'b0, s} < (d - 4'd5));
        end else begin
            r = 1'b1;
        end
        return r;
    endfunction

    assign cnt_inc_s = cnt_r + CW'(1);
    assign on_len_s  = is_dash(target_r, sym_r) ? CW'(DASH_UNITS) : CW'(DOT_UNITS);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= S_IDLE;
            q_r      <= 4'd0;
            target_r <= 4'd0;
            sym_r    <= 3'd0;
            cnt_r    <= '0;
            score_r  <= 4'd0;
            round_r  <= 4'd0;
            hit_r    <= 1'b0;
        end else begin
            state_r  <= state_nx;
            q_r      <= q_r + 4'd1;
            target_r <= target_nx;
            sym_r    <= sym_nx;
            cnt_r    <= cnt_nx;
            score_r  <= score_nx;
            round_r  <= round_nx;
            hit_r    <= hit_nx;
        end
    end

    // Next-state and datapath update logic.
    always_comb begin
        state_nx  = state_r;
        target_nx = target_r;
        sym_nx    = sym_r;
        cnt_nx    = cnt_r;
        score_nx  = score_r;
        round_nx  = round_r;
        hit_nx    = hit_r;
        case (state_r)
            S_IDLE, S_OVER: begin
                if (start) begin
                    score_nx = 4'd0;
                    round_nx = 4'd0;
                    state_nx = S_LOAD;
                end else begin
                    state_nx = state_r;
                end
            end
            S_LOAD: begin
                target_nx = morse_number;
                sym_nx    = 3'd0;
                cnt_nx    = '0;
                state_nx  = S_PLAY_ON;
            end
            S_PLAY_ON: begin
                if (!tick) begin
                    cnt_nx = cnt_r;
                end else if (cnt_inc_s == on_len_s) begin
                    cnt_nx   = '0;
                    state_nx = S_PLAY_GAP;
                end else begin
                    cnt_nx = cnt_inc_s;
                end
            end
            S_PLAY_GAP: begin
                if (!tick) begin
                    cnt_nx = cnt_r;
                end else if (cnt_inc_s != CW'(GAP_UNITS)) begin
                    cnt_nx = cnt_inc_s;
                end else if (sym_r == 3'd4) begin
                    cnt_nx   = '0;
                    state_nx = S_WAIT_ANS;
                end else begin
                    cnt_nx   = '0;
                    sym_nx   = sym_r + 3'd1;
                    state_nx = S_PLAY_ON;
                end
            end
            S_WAIT_ANS: begin
                // A real answer beats a timeout landing on the same tick.
                if (answer_valid) begin
                    hit_nx   = (answer_digit == target_r);
                    state_nx = S_RESULT;
                end else if (tick && (cnt_inc_s == CW'(TIMEOUT_UNITS))) begin
                    hit_nx   = 1'b0;
                    state_nx = S_RESULT;
                end else if (tick) begin
                    cnt_nx = cnt_inc_s;
                end else begin
                    cnt_nx = cnt_r;
                end
            end
            S_RESULT: begin
                if (hit_r && (score_r != 4'd15)) begin
                    score_nx = score_r + 4'd1;
                end else begin
                    score_nx = score_r;
                end
                round_nx = round_r + 4'd1;
                if ((round_r + 4'd1) == 4'(ROUNDS)) begin
                    state_nx = S_OVER;
                end else begin
                    state_nx = S_LOAD;
                end
            end
            default: begin
                state_nx = S_IDLE;
            end
        endcase
    end

    assign q            = q_r;
    assign led          = (state_r == S_PLAY_ON);
    assign busy         = (state_r != S_IDLE) && (state_r != S_OVER);
    assign await_answer = (state_r == S_WAIT_ANS);
    assign correct      = (state_r == S_RESULT) && hit_r;
    assign wrong        = (state_r == S_RESULT) && !hit_r;
    assign score        = score_r;
    assign round        = round_r;
    assign game_over    = (state_r == S_OVER);

endmodule
